// File: rtl/dmg_serial_link.sv
// dmg_serial_link: DMG link-port transfer unit. It holds the 8-bit SB shift
// register and the SC control. SB is sent MSB-first on sout while sin is
// shifted into the LSB. The unit runs as SCK master or as SCK slave.
// Optional feature macro: DMG_SERIAL_FAST_EN. When it is defined, sc_fast
// selects a master half-period of CLK_DIV/32 cycles (minimum 1).
module dmg_serial_link #(
    parameter int unsigned CLK_DIV     = 256,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  INIT_SB     = 8'h00
) (
    input  logic       dffra_clk,
    input  logic       nreset,
    input  logic       sb_wr,
    input  logic [7:0] sb_wdata,
    input  logic       sc_wr,
    input  logic       sc_start,
    input  logic       sc_int_clk,
    input  logic       sc_fast,
    input  logic       sin,
    input  logic       sck_in,
    output logic [7:0] sb_rdata,
    output logic       sc_busy,
    output logic       sout,
    output logic       sck_out,
    output logic       sck_oe,
    output logic       irq
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        XFER_LOW  = 2'd1,
        XFER_HIGH = 2'd2
    } state_t;

    localparam int unsigned      DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned      FAST_HALF = (CLK_DIV / 32 > 0) ? CLK_DIV / 32 : 1;
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_HALF - 1);

    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_sb, w_sb_nxt;
    logic                   r_sout, w_sout_nxt;
    logic                   r_sck_out, w_sck_out_nxt;
    logic                   r_sck_oe, w_sck_oe_nxt;
    logic                   r_irq, w_irq_nxt;
    logic [2:0]             r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0]       r_div, w_div_nxt;
    logic                   r_mode, w_mode_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_sin_sync;
    logic                   r_sck_prev;
    logic                   w_sck_s, w_sin_s;
    logic                   w_div_last_hit;
    logic                   w_edge_fall, w_edge_rise;
    logic [DIV_W-1:0]       w_div_last;

`ifdef DMG_SERIAL_FAST_EN
    logic                   r_fast;
    logic                   w_start;

    assign w_start    = (r_state == IDLE) && sc_wr && sc_start;
    assign w_div_last = r_fast ? FAST_LAST : SLOW_LAST;

    // Latch the speed select together with the mode at transfer start.
    always_ff @(posedge dffra_clk or negedge nreset) begin
        if (!nreset)      r_fast <= 1'b0;
        else if (w_start) r_fast <= sc_fast;
    end
`else
    logic                   w_unused_fast;

    assign w_unused_fast = sc_fast;
    assign w_div_last    = SLOW_LAST;
`endif

    // Bring the cable clock and data into the dffra_clk domain. The lines idle high.
    always_ff @(posedge dffra_clk or negedge nreset) begin
        if (!nreset) begin
            r_sck_sync <= '1;
            r_sin_sync <= '1;
            r_sck_prev <= 1'b1;
        end else begin
            // NOTE: clocked state always uses <= so every flop samples pre-edge values.
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
            r_sin_sync <= {r_sin_sync[SYNC_STAGES-2:0], sin};
            r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    assign w_sck_s        = r_sck_sync[SYNC_STAGES-1];
    assign w_sin_s        = r_sin_sync[SYNC_STAGES-1];
    assign w_div_last_hit = (r_div == w_div_last);
    assign w_edge_fall    = r_mode ? w_div_last_hit : (r_sck_prev & ~w_sck_s);
    assign w_edge_rise    = r_mode ? w_div_last_hit : (~r_sck_prev & w_sck_s);

    // Register the FSM state and all datapath state.
    always_ff @(posedge dffra_clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= IDLE;
            r_sb      <= INIT_SB;
            r_sout    <= 1'b1;
            r_sck_out <= 1'b1;
            r_sck_oe  <= 1'b0;
            r_irq     <= 1'b0;
            r_cnt     <= '0;
            r_div     <= '0;
            r_mode    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sb      <= w_sb_nxt;
            r_sout    <= w_sout_nxt;
            r_sck_out <= w_sck_out_nxt;
            r_sck_oe  <= w_sck_oe_nxt;
            r_irq     <= w_irq_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_mode    <= w_mode_nxt;
        end
    end

    // Compute the next state: start, abort, the SCK falling edge and the SCK rising edge.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_state_nxt   = r_state;
        w_sb_nxt      = r_sb;
        w_sout_nxt    = r_sout;
        w_sck_out_nxt = r_sck_out;
        w_sck_oe_nxt  = r_sck_oe;
        w_irq_nxt     = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_mode_nxt    = r_mode;
        case (r_state)
            IDLE: begin
                if (sb_wr) w_sb_nxt = sb_wdata;
                if (sc_wr && sc_start) begin
                    w_mode_nxt    = sc_int_clk;
                    w_sck_oe_nxt  = sc_int_clk;
                    w_div_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_sck_out_nxt = 1'b1;
                    w_state_nxt   = XFER_HIGH;
                end
            end
            XFER_HIGH, XFER_LOW: begin
                if (sc_wr && !sc_start) begin
                    // Abort: keep the partial SB and the last sout; raise no interrupt.
                    w_state_nxt   = IDLE;
                    w_sck_out_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_div_nxt     = '0;
                end else begin
                    if (r_mode) w_div_nxt = w_div_last_hit ? '0 : r_div + DIV_W'(1);
                    if (r_state == XFER_HIGH) begin
                        if (w_edge_fall) begin
                            w_sout_nxt    = r_sb[7];
                            w_sck_out_nxt = ~r_mode;
                            w_state_nxt   = XFER_LOW;
                        end
                    end else if (w_edge_rise) begin
                        w_sb_nxt      = {r_sb[6:0], w_sin_s};
                        w_cnt_nxt     = r_cnt + 3'd1;
                        w_sck_out_nxt = 1'b1;
                        if (r_cnt == 3'd7) begin
                            w_state_nxt = IDLE;
                            w_irq_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = XFER_HIGH;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign sb_rdata = r_sb;
    assign sc_busy  = (r_state != IDLE);
    assign sout     = r_sout;
    assign sck_out  = r_sck_out;
    assign sck_oe   = r_sck_oe;
    assign irq      = r_irq;

endmodule
